if_id_pipe_reg: RTL



---
 rtl/pipe_pkg.sv | 21 ++
 rtl/imm_sign_ext.sv | 13 +
 rtl/if_id_pipe_reg.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit pipeline: field widths, IF/ID state
// encoding and the immediate sign-extension helper.
package pipe_pkg;

  localparam int OPC_W   = 4;
  localparam int RADDR_W = 4;
  localparam int IMM_W   = 4;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  // Sign-extend the low imm_w bits of field to 32 bits; the caller truncates
  // to its data width, so data_w == imm_w degenerates to a pass-through.
  function automatic logic [31:0] sign_ext(input logic [31:0] field, input int imm_w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      r[5'(i)] = (i < imm_w) ? field[5'(i)] : field[5'(imm_w - 1)];
    return r;
  endfunction

endpackage

// File: rtl/imm_sign_ext.sv
// Combinational immediate sign extender, shared by the ID and EX stages.
module imm_sign_ext #(
  parameter int IMM_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic [IMM_W-1:0]  field,
  output logic [DATA_W-1:0] value
);
  import pipe_pkg::*;

  assign value = DATA_W'(sign_ext(32'(field), IMM_W));

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with stall hold and multi-cycle flush bubbles.
// Optional statistics counters are compiled in with IFID_STATS_EN.
module if_id_pipe_reg #(
  parameter int INSTR_W   = 16,
  parameter int PC_W      = 6,
  parameter int OPC_W     = 4,
  parameter int RADDR_W   = 4,
  parameter int IMM_W     = 4,
  parameter int DATA_W    = 16,
  parameter int FLUSH_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               in_valid,
  input  logic               in_stall,
  input  logic               in_flush,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [RADDR_W-1:0] out_op1_addr,
  output logic [RADDR_W-1:0] out_op2_addr,
  output logic [DATA_W-1:0]  out_imm_se,
  output logic               out_bubble,
`ifdef IFID_STATS_EN
  output logic [15:0]        out_bubble_cnt,
  output logic [15:0]        out_stall_cnt,
`endif
  output logic               out_busy
);
  import pipe_pkg::*;

  localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               valid_d, bubble_d, busy_d;
  logic [PC_W-1:0]    pc_d;
  logic [OPC_W-1:0]   opc_d;
  logic [RADDR_W-1:0] op1_d, op2_d;
  logic [DATA_W-1:0]  imm_d, imm_in;
  logic               clear, capture;

  imm_sign_ext #(.IMM_W(IMM_W), .DATA_W(DATA_W)) u_sext (
    .field (in_instr[IMM_W-1:0]),
    .value (imm_in)
  );

  // Next state, flush counter and next output values (default: hold).
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    clear    = 1'b0;
    capture  = 1'b0;
    valid_d  = out_valid;
    pc_d     = out_pc;
    opc_d    = out_opcode;
    op1_d    = out_op1_addr;
    op2_d    = out_op2_addr;
    imm_d    = out_imm_se;
    bubble_d = out_bubble;
    case (state)
      RUN: begin
        if (in_flush) begin
          clear = 1'b1;
          if (FLUSH_CYC > 1) begin
            state_d = FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYC - 1);
          end
        end else if (!in_stall) begin
          capture = 1'b1;
        end
      end
      FLUSH: begin
        if (in_flush) begin
          clear = 1'b1;
          cnt_d = CNT_W'(FLUSH_CYC - 1);
        end else if (cnt == '0) begin
          state_d = RUN;
          capture = 1'b1;
        end else begin
          clear = 1'b1;
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (clear) begin
      valid_d  = 1'b0;
      pc_d     = '0;
      opc_d    = '0;
      op1_d    = '0;
      op2_d    = '0;
      imm_d    = '0;
      bubble_d = 1'b1;
    end
    if (capture) begin
      valid_d  = in_valid;
      bubble_d = 1'b0;
      pc_d     = in_valid ? in_pc : '0;
      opc_d    = in_valid ? in_instr[INSTR_W-1 -: OPC_W] : '0;
      op1_d    = in_valid ? in_instr[INSTR_W-OPC_W-1 -: RADDR_W] : '0;
      op2_d    = in_valid ? in_instr[INSTR_W-OPC_W-RADDR_W-1 -: RADDR_W] : '0;
      imm_d    = in_valid ? imm_in : '0;
    end
    // Busy only while the following edge is guaranteed not to capture; the
    // last bubble edge (counter at 0) already accepts the IF instruction next.
    busy_d = (state_d == FLUSH) && (cnt_d != '0);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= '0;
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_opcode   <= '0;
      out_op1_addr <= '0;
      out_op2_addr <= '0;
      out_imm_se   <= '0;
      out_bubble   <= 1'b0;
      out_busy     <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      out_valid    <= valid_d;
      out_pc       <= pc_d;
      out_opcode   <= opc_d;
      out_op1_addr <= op1_d;
      out_op2_addr <= op2_d;
      out_imm_se   <= imm_d;
      out_bubble   <= bubble_d;
      out_busy     <= busy_d;
    end
  end

`ifdef IFID_STATS_EN
  // Saturating counts of bubble edges and honoured stall edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_bubble_cnt <= '0;
      out_stall_cnt  <= '0;
    end else begin
      if (bubble_d && out_bubble_cnt != 16'hFFFF)
        out_bubble_cnt <= out_bubble_cnt + 16'd1;
      if (state == RUN && in_stall && !in_flush && out_stall_cnt != 16'hFFFF)
        out_stall_cnt <= out_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
